// File: rtl/vend_dispenser_pkg.sv
// Shared encodings for the product dispenser.
// These are kept identical to the upstream vending FSM so that product and change codes pass through unchanged.
package vend_dispenser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    MOTOR  = 3'd2,
    EJ_HI  = 3'd3,
    EJ_LO  = 3'd4,
    DONE   = 3'd5,
    JAM    = 3'd6
  } state_t;

  localparam logic [1:0] PROD_A = 2'b00;
  localparam logic [1:0] PROD_B = 2'b01;
  localparam logic [1:0] PROD_C = 2'b10;
  localparam logic [1:0] PROD_D = 2'b11;

  localparam logic [2:0] CHG_NONE = 3'b000;
  localparam logic [2:0] CHG_5    = 3'b001;
  localparam logic [2:0] CHG_10   = 3'b010;
  localparam logic [2:0] CHG_15   = 3'b100;

  // Number of 5-unit coins owed. Anything that is not a clean one-hot code pays nothing.
  function automatic logic [1:0] coin_count(input logic [2:0] chg);
    case (chg)
      CHG_5:   return 2'd1;
      CHG_10:  return 2'd2;
      CHG_15:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Returns the one-hot slot motor drive for the given product.
  function automatic logic [3:0] prod_onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/vend_dispenser_pulse_timer.sv
// Loadable down-counter with a zero flag.
// A single instance times both the motor timeout and the eject high and low phases.
module pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load a new interval, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/vend_dispenser.sv
// Product dispenser: it checks stock, runs the slot motor until the drop sensor fires, ejects change coins and tracks per-product stock.
// Every output is registered and is derived from the next-state value, so each output lines up with the state it belongs to.
module vend_dispenser
  import vend_dispenser_pkg::*;
#(
  parameter int         MOTOR_TIMEOUT = 16,
  parameter int         EJECT_HIGH    = 2,
  parameter int         EJECT_LOW     = 2,
  parameter logic [3:0] STOCK_INIT    = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] product,
  input  logic [2:0] change,
  input  logic       drop_sense,
  input  logic       restock,
  output logic [3:0] motor,
  output logic       eject,
  output logic       busy,
  output logic       done,
  output logic       sold_out,
  output logic       jam,
  output logic [3:0] empty
);

  localparam int TW = 8;
  // The timer is loaded with N-1, so a phase lasts N cycles and ends on the cycle where zero is seen.
  localparam logic [TW-1:0] LD_MOTOR = TW'(MOTOR_TIMEOUT - 1);
  localparam logic [TW-1:0] LD_HI    = TW'(EJECT_HIGH - 1);
  localparam logic [TW-1:0] LD_LO    = TW'(EJECT_LOW - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_product;
  logic [1:0]  r_coins, w_coins_nxt;
  logic [3:0]  r_stock [4];
  logic [3:0]  w_stock_nxt [4];
  logic        w_sold_out_nxt;
  logic        w_stock_zero;
  logic        w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic        w_tmr_zero;
  logic [3:0]  r_motor, r_empty;
  logic        r_eject, r_busy, r_done, r_sold_out, r_jam;

  pulse_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  assign w_stock_zero = (r_stock[r_product] == 4'd0);

  // Next-state, coin, stock and timer-load decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_coins_nxt    = r_coins;
    w_sold_out_nxt = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;
    for (int i = 0; i < 4; i++) w_stock_nxt[i] = r_stock[i];
    case (r_state)
      IDLE: begin
        if (restock)
          for (int i = 0; i < 4; i++) w_stock_nxt[i] = STOCK_INIT;
        if (vend_req) begin
          w_state_nxt = CHECK;
          w_coins_nxt = coin_count(change);
        end
      end
      CHECK: begin
        if (w_stock_zero) begin
          w_sold_out_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_state_nxt = MOTOR;
          w_tmr_load  = 1'b1;
          w_tmr_val   = LD_MOTOR;
        end
      end
      MOTOR: begin
        if (drop_sense) begin
          if (!w_stock_zero) w_stock_nxt[r_product] = r_stock[r_product] - 4'd1;
          if (r_coins != 2'd0) begin
            w_state_nxt = EJ_HI;
            w_tmr_load  = 1'b1;
            w_tmr_val   = LD_HI;
          end else begin
            w_state_nxt = DONE;
          end
        end else if (w_tmr_zero) begin
          w_state_nxt = JAM;
        end
      end
      EJ_HI: begin
        if (w_tmr_zero) begin
          w_state_nxt = EJ_LO;
          w_tmr_load  = 1'b1;
          w_tmr_val   = LD_LO;
        end
      end
      EJ_LO: begin
        if (w_tmr_zero) begin
          w_coins_nxt = r_coins - 2'd1;
          if (r_coins > 2'd1) begin
            w_state_nxt = EJ_HI;
            w_tmr_load  = 1'b1;
            w_tmr_val   = LD_HI;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      JAM:     w_state_nxt = JAM;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, coin count, stock and registered outputs; reset abandons any vend immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_coins    <= 2'd0;
      for (int i = 0; i < 4; i++) r_stock[i] <= STOCK_INIT;
      r_motor    <= 4'd0;
      r_eject    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sold_out <= 1'b0;
      r_jam      <= 1'b0;
      r_empty    <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_coins    <= w_coins_nxt;
      for (int i = 0; i < 4; i++) begin
        r_stock[i] <= w_stock_nxt[i];
        r_empty[i] <= (w_stock_nxt[i] == 4'd0);
      end
      r_motor    <= (w_state_nxt == MOTOR) ? prod_onehot(r_product) : 4'd0;
      r_eject    <= (w_state_nxt == EJ_HI);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
      r_sold_out <= w_sold_out_nxt;
      r_jam      <= (w_state_nxt == JAM);
    end
  end

  // Capture the selected product when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && vend_req)
      r_product <= product;
  end

  assign motor    = r_motor;
  assign eject    = r_eject;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sold_out = r_sold_out;
  assign jam      = r_jam;
  assign empty    = r_empty;

endmodule
